// File: rtl/whack_mole_core.sv
// whack_mole_core: whack-a-mole game engine with a shrinking reaction window and score/miss/round tracking.
// Optional macro WRONG_PENALTY_EN makes a wrong-button press in SHOW count as a miss.
module whack_mole_core #(
   parameter int          N_MOLES    = 8,
   parameter int          SCORE_W    = 8,
   parameter int          ROUNDS     = 16,
   parameter int          MISS_LIMIT = 3,
   parameter int          WIN_INIT   = 500000,
   parameter int          WIN_MIN    = 100000,
   parameter int          WIN_STEP   = 25000,
   parameter int          GAP_CYCLES = 200000,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [N_MOLES-1:0] btn,
   output logic [N_MOLES-1:0] mole,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         misses,
   output logic [7:0]         round,
   output logic               busy,
   output logic               game_end,
   output logic               hit_pulse,
   output logic               miss_pulse
);
   localparam int TW = $clog2(WIN_INIT + WIN_STEP + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam int IW = $clog2(N_MOLES);
   localparam logic [TW-1:0] W_INIT  = TW'(WIN_INIT);
   localparam logic [TW-1:0] W_MIN   = TW'(WIN_MIN);
   localparam logic [TW-1:0] W_STEP  = TW'(WIN_STEP);
   localparam logic [TW-1:0] W_FLOOR = TW'(WIN_MIN + WIN_STEP);
   localparam logic [GW-1:0] G_LAST  = GW'(GAP_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_t;
   state_t             state;
   logic [N_MOLES-1:0] s1, s2, s3, rise;
   logic [15:0]        lfsr;
   logic [TW-1:0]      win_len, timer;
   logic [GW-1:0]      gap_cnt;
   logic [IW-1:0]      prev, pick;
   logic               prev_ok, hit, miss, last;
   logic [4:0]         r0, r1;
   assign rise = s2 & ~s3;
   assign hit  = |(rise & mole);
`ifdef WRONG_PENALTY_EN
   logic wrong;
   assign wrong = |(rise & ~mole);
   assign miss  = !hit && (timer == win_len - TW'(1) || wrong);
`else
   assign miss  = !hit && timer == win_len - TW'(1);
`endif
   // hit has priority, so a hit can never also be the game-ending miss
   assign last = round == 8'(ROUNDS) || (miss && misses + 4'd1 == 4'(MISS_LIMIT));
   assign r0   = 5'(lfsr[3:0]) % 5'(N_MOLES);
   assign r1   = (prev_ok && r0 == 5'(prev)) ? ((r0 == 5'(N_MOLES - 1)) ? 5'd0 : r0 + 5'd1) : r0;
   assign pick = IW'(r1);
   assign busy = state == GAP || state == SHOW;
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         lfsr       <= LFSR_SEED;
         s1         <= '0;
         s2         <= '0;
         s3         <= '0;
         win_len    <= W_INIT;
         timer      <= '0;
         gap_cnt    <= '0;
         prev       <= '0;
         prev_ok    <= 1'b0;
         mole       <= '0;
         score      <= '0;
         misses     <= '0;
         round      <= '0;
         game_end   <= 1'b0;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
      end else begin
         lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         s1         <= btn;
         s2         <= s1;
         s3         <= s2;
         hit_pulse  <= 1'b0;
         miss_pulse <= 1'b0;
         case (state)
            IDLE, DONE: if (start) begin
               state    <= GAP;
               game_end <= 1'b0;
               score    <= '0;
               misses   <= '0;
               round    <= '0;
               win_len  <= W_INIT;
               gap_cnt  <= '0;
               prev_ok  <= 1'b0;
            end
            GAP: if (gap_cnt == G_LAST) begin
               state   <= SHOW;
               mole    <= {{(N_MOLES-1){1'b0}}, 1'b1} << pick;
               prev    <= pick;
               prev_ok <= 1'b1;
               round   <= round + 8'd1;
               timer   <= '0;
            end else gap_cnt <= gap_cnt + GW'(1);
            SHOW: if (hit || miss) begin
               state      <= last ? DONE : GAP;
               game_end   <= last;
               mole       <= '0;
               gap_cnt    <= '0;
               hit_pulse  <= hit;
               miss_pulse <= miss;
               if (hit) begin
                  score   <= score == '1 ? score : score + SCORE_W'(1);
                  win_len <= win_len >= W_FLOOR ? win_len - W_STEP : W_MIN;
               end else begin
                  misses <= misses + 4'd1;
`ifdef WRONG_PENALTY_EN
                  if (wrong && score != '0) score <= score - SCORE_W'(1);
`endif
               end
            end else timer <= timer + TW'(1);
         endcase
      end
   end
endmodule

// File: tb/tb_whack_mole_core.sv
// tb_whack_mole_core: table-driven game scenarios plus random play, all checked every cycle against
// a behavioural model of the game rules (honours WRONG_PENALTY_EN when defined).
module tb_whack_mole_core;
   localparam int N = 4, SW = 8, RN = 4, ML = 2, WI = 20, WM = 8, WS = 4, GC = 5;
   localparam logic [15:0] SEED = 16'hACE1;
`ifdef WRONG_PENALTY_EN
   localparam bit PEN = 1'b1;
`else
   localparam bit PEN = 1'b0;
`endif
   logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [N-1:0]  btn = '0, mole;
   logic [SW-1:0] score;
   logic [3:0]    misses;
   logic [7:0]    round;
   logic          busy, game_end, hit_pulse, miss_pulse;
   int n_cmp = 0, n_fail = 0;
   always #5 clk = ~clk;
   whack_mole_core #(.N_MOLES(N), .SCORE_W(SW), .ROUNDS(RN), .MISS_LIMIT(ML), .WIN_INIT(WI),
      .WIN_MIN(WM), .WIN_STEP(WS), .GAP_CYCLES(GC), .LFSR_SEED(SEED)) dut (
      .clk(clk), .rst(rst), .start(start), .btn(btn), .mole(mole), .score(score), .misses(misses),
      .round(round), .busy(busy), .game_end(game_end), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse));
   // model: 0 idle, 1 gap, 2 show, 3 done; m_left counts cycles remaining in the phase
   int m_state, m_left, m_mole, m_prev, m_score, m_miss, m_round, m_win;
   bit m_hit, m_missp;
   logic [15:0] m_lfsr;
   logic [N-1:0] h1, h2, h3;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic model_step();
      logic [N-1:0] rise;
      bit hit, wrong;
      int idx;
      if (rst) begin
         m_state = 0; m_left = 0; m_mole = -1; m_prev = -1; m_score = 0; m_miss = 0; m_round = 0;
         m_win = WI; m_hit = 0; m_missp = 0; m_lfsr = SEED; h1 = '0; h2 = '0; h3 = '0;
         return;
      end
      rise = h2 & ~h3;
      h3 = h2; h2 = h1; h1 = btn;
      m_hit = 0; m_missp = 0;
      case (m_state)
         0, 3: if (start) begin
            m_state = 1; m_left = GC; m_score = 0; m_miss = 0; m_round = 0; m_win = WI; m_prev = -1;
         end
         1: begin
            m_left--;
            if (m_left == 0) begin
               idx = int'(m_lfsr[3:0]);
               while (idx >= N) idx -= N;
               if (idx == m_prev) idx = (idx + 1) % N;
               m_mole = idx; m_prev = idx; m_round++; m_state = 2; m_left = m_win;
            end
         end
         default: begin
            hit = rise[m_mole];
            wrong = (rise & ~(N'(1) << m_mole)) != '0;
            m_left--;
            if (hit || m_left == 0 || (PEN && wrong)) begin
               if (hit) begin
                  m_hit = 1;
                  if (m_score < (1 << SW) - 1) m_score++;
                  m_win = (m_win - WS < WM) ? WM : m_win - WS;
               end else begin
                  m_missp = 1;
                  m_miss++;
                  if (PEN && wrong && m_score > 0) m_score--;
               end
               m_state = (m_round == RN || m_miss == ML) ? 3 : 1;
               m_left = GC;
            end
         end
      endcase
      m_lfsr = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
   endtask
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      chk("cyc_mole", mole, m_state == 2 ? (32'd1 << m_mole) : 32'd0);
      chk("cyc_score", score, m_score);
      chk("cyc_misses", misses, m_miss);
      chk("cyc_round", round, m_round);
      chk("cyc_busy", busy, m_state == 1 || m_state == 2);
      chk("cyc_game_end", game_end, m_state == 3);
      chk("cyc_hit_pulse", hit_pulse, m_hit);
      chk("cyc_miss_pulse", miss_pulse, m_missp);
   endtask
   task automatic wait_mole();
      for (int k = 0; k < 100 && mole == '0; k++) tick();
      if (mole == '0) chk("mole_timeout", 0, 1);
   endtask
   typedef struct {
      bit new_game; int delay; bit exp_hit; int exp_len; int exp_score; int exp_misses; int exp_round; bit exp_end;
   } row_t;
   row_t rows[11];
   logic [N-1:0] prev_m, seq[$], seq_first[$];
   task automatic run_row(input int i);
      int len;
      if (rows[i].new_game) begin
         start = 1'b1; tick(); start = 1'b0;
      end
      wait_mole();
      if (!rows[i].new_game) chk("mole_repeat", mole == prev_m, 0);
      prev_m = mole;
      seq.push_back(mole);
      len = 0;
      while (mole != '0 && len < 40) begin
         if (len == rows[i].delay) btn = mole;
         tick();
         len++;
      end
      btn = '0;
      chk($sformatf("row%0d_show_len", i), len, rows[i].exp_len);
      chk($sformatf("row%0d_hit", i), hit_pulse, rows[i].exp_hit);
      chk($sformatf("row%0d_miss", i), miss_pulse, !rows[i].exp_hit);
      chk($sformatf("row%0d_score", i), score, rows[i].exp_score);
      chk($sformatf("row%0d_misses", i), misses, rows[i].exp_misses);
      chk($sformatf("row%0d_round", i), round, rows[i].exp_round);
      chk($sformatf("row%0d_end", i), game_end, rows[i].exp_end);
   endtask
   initial begin
      logic [N-1:0] lit, w;
      // presses at delay W-3 land on the timer's last cycle, so these also measure the window
      rows[0]  = '{1, 17, 1, 20, 1, 0, 1, 0};
      rows[1]  = '{0, 13, 1, 16, 2, 0, 2, 0};
      rows[2]  = '{0,  9, 1, 12, 3, 0, 3, 0};
      rows[3]  = '{0,  5, 1,  8, 4, 0, 4, 1};
      rows[4]  = '{1,  0, 1,  3, 1, 0, 1, 0};
      rows[5]  = '{0,  2, 1,  5, 2, 0, 2, 0};
      rows[6]  = '{0,  4, 1,  7, 3, 0, 3, 0};
      rows[7]  = '{0,  1, 1,  4, 4, 0, 4, 1};
      rows[8]  = '{1, -1, 0, 20, 0, 1, 1, 0};
      rows[9]  = '{0, -1, 0, 20, 0, 2, 2, 1};
      rows[10] = '{1,  1, 1,  4, 1, 0, 1, 0};
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      for (int k = 0; k < 50; k++) tick();
      chk("idle_mole", mole, 0);
      chk("idle_busy", busy, 0);
      chk("idle_score", score, 0);
      chk("idle_end", game_end, 0);
      for (int i = 0; i < 11; i++) run_row(i);
      seq_first = seq;
      wait_mole();
      lit = mole;
      w = {lit[N-2:0], lit[N-1]};
      btn = w;
      for (int k = 0; k < 6; k++) tick();
      btn = '0;
      if (PEN) begin
         chk("pen_score", score, 0);
         chk("pen_misses", misses, 1);
         wait_mole();
         lit = mole;
         btn = {lit[N-2:0], lit[N-1]};
         for (int k = 0; k < 6; k++) tick();
         btn = '0;
         chk("pen_floor_score", score, 0);
         chk("pen_floor_misses", misses, 2);
         chk("pen_floor_end", game_end, 1);
         start = 1'b1; tick(); start = 1'b0;
         wait_mole();
      end else begin
         chk("nopen_mole", mole, lit);
         chk("nopen_score", score, 1);
         chk("nopen_misses", misses, 0);
         tick();
         btn = {lit[N-3:0], lit[N-1:N-2]};
         for (int k = 0; k < 6; k++) tick();
         btn = '0;
         chk("nopen2_mole", mole, lit);
         chk("nopen2_score", score, 1);
         chk("nopen2_misses", misses, 0);
      end
      chk("pre_rst_show", mole != '0, 1);
      rst = 1'b1; tick(); rst = 1'b0;
      chk("rst_mole", mole, 0);
      chk("rst_round", round, 0);
      chk("rst_busy", busy, 0);
      chk("rst_score", score, 0);
      for (int k = 0; k < 50; k++) tick();
      seq.delete();
      for (int i = 0; i < 4; i++) run_row(i);
      for (int i = 0; i < 4; i++) chk($sformatf("replay_mole%0d", i), seq[i], seq_first[i]);
      for (int k = 0; k < 4000; k++) begin
         rst = $urandom_range(0, 599) == 0;
         start = $urandom_range(0, 15) == 0;
         if ($urandom_range(0, 7) == 0) btn = mole;
         else if ($urandom_range(0, 5) == 0) btn = N'($urandom_range(0, (1 << N) - 1));
         else if ($urandom_range(0, 3) == 0) btn = '0;
         tick();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
